// File: rtl/mole_ctrl.sv
// Whack-a-mole round controller: lights one pseudo-random target per tick,
// scores button hits, charges lives on timeouts and raises difficulty.
module mole_ctrl #(
    parameter int         NUM_TARGETS   = 8,
    parameter int         SHOW_TICKS    = 3,
    parameter int         LEVEL_UP_HITS = 5,
    parameter int         MAX_DIFF      = 4,
    parameter int         START_LIVES   = 3,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   tick,
    input  logic [NUM_TARGETS-1:0] hit,
    output logic [NUM_TARGETS-1:0] targets,
    output logic [15:0]            score,
    output logic [2:0]             difficulty,
    output logic [2:0]             lives,
    output logic                   game_over,
    output logic                   hit_pulse,
    output logic                   miss_pulse
);
    localparam int IW = $clog2(NUM_TARGETS);
    localparam int TW = ($clog2(SHOW_TICKS) > 0) ? $clog2(SHOW_TICKS) : 1;
    localparam int HW = ($clog2(LEVEL_UP_HITS) > 0) ? $clog2(LEVEL_UP_HITS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, SHOW, GAMEOVER} state_t;

    state_t                 state;
    logic [7:0]             lfsr;
    logic [NUM_TARGETS-1:0] hit_q;
    logic [TW-1:0]          tick_cnt;
    logic [HW-1:0]          hits_in_level;
    logic [IW-1:0]          prev_idx;

    logic                   lfsr_fb;
    logic [IW-1:0]          idx_raw;
    logic [IW-1:0]          idx;
    logic                   press_lit;

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign idx_raw   = IW'(lfsr % 8'(NUM_TARGETS));
    // Bump to the next target (wrapping) so a spawn never repeats the last one.
    assign idx       = (idx_raw != prev_idx)               ? idx_raw :
                       (idx_raw == IW'(NUM_TARGETS - 1))   ? '0      : idx_raw + 1'b1;
    assign press_lit = |(hit & ~hit_q & targets);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            targets       <= '0;
            score         <= '0;
            difficulty    <= '0;
            lives         <= 3'(START_LIVES);
            game_over     <= 1'b0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            lfsr          <= LFSR_SEED;
            hit_q         <= '0;
            tick_cnt      <= '0;
            hits_in_level <= '0;
            prev_idx      <= '0;
        end else begin
            hit_q      <= hit;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (enable)
                lfsr <= {lfsr[6:0], lfsr_fb};

            if (!enable) begin
                state     <= IDLE;
                targets   <= '0;
                game_over <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        targets       <= '0;
                        game_over     <= 1'b0;
                        score         <= '0;
                        difficulty    <= '0;
                        hits_in_level <= '0;
                        tick_cnt      <= '0;
                        lives         <= 3'(START_LIVES);
                        state         <= WAIT;
                    end
                    WAIT: begin
                        targets <= '0;
                        if (tick) begin
                            targets  <= NUM_TARGETS'(1) << idx;
                            prev_idx <= idx;
                            tick_cnt <= '0;
                            state    <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (press_lit) begin
                            if (score != 16'hFFFF)
                                score <= score + 16'd1;
                            hit_pulse <= 1'b1;
                            targets   <= '0;
                            if (hits_in_level == HW'(LEVEL_UP_HITS - 1)) begin
                                hits_in_level <= '0;
                                if (difficulty < 3'(MAX_DIFF))
                                    difficulty <= difficulty + 3'd1;
                            end else begin
                                hits_in_level <= hits_in_level + 1'b1;
                            end
                            state <= WAIT;
                        end else if (tick && tick_cnt == TW'(SHOW_TICKS - 1)) begin
                            miss_pulse <= 1'b1;
                            targets    <= '0;
                            if (lives != 3'd0)
                                lives <= lives - 3'd1;
                            if (lives <= 3'd1) begin
                                game_over <= 1'b1;
                                state     <= GAMEOVER;
                            end else begin
                                state <= WAIT;
                            end
                        end else if (tick) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    GAMEOVER: begin
                        targets   <= '0;
                        game_over <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mole_ctrl.sv
// Directed scoreboard bench for mole_ctrl: expected outputs are queued as each
// step is driven and compared one cycle later.
module tb_mole_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tick = 1'b0;
    logic [7:0]  hit = '0;
    logic [7:0]  targets;
    logic [15:0] score;
    logic [2:0]  difficulty;
    logic [2:0]  lives;
    logic        game_over, hit_pulse, miss_pulse;

    mole_ctrl #(
        .NUM_TARGETS(8), .SHOW_TICKS(3), .LEVEL_UP_HITS(5),
        .MAX_DIFF(4), .START_LIVES(3), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick), .hit(hit),
        .targets(targets), .score(score), .difficulty(difficulty), .lives(lives),
        .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  t;
        logic [15:0] s;
        logic [2:0]  d;
        logic [2:0]  l;
        logic        go;
        logic        hp;
        logic        mp;
    } snap_t;

    snap_t sb[$];
    int    nvec = 0;
    int    nerr = 0;

    // Independent reference LFSR (x^8+x^6+x^5+x^4+1), advancing while enabled.
    logic [7:0] lfsr_m;
    always @(posedge clk or posedge rst)
        if (rst)         lfsr_m <= 8'hA5;
        else if (enable) lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

    logic [7:0]  e_t = '0;
    logic [15:0] e_s = '0;
    logic [2:0]  e_d = '0;
    logic [2:0]  e_l = 3'd3;
    logic        e_go = 1'b0;
    int          prev_m = 0;
    logic [7:0]  last_t = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic t, input logic [7:0] h, input logic hp, input logic mp);
        snap_t e;
        tick = t;
        hit  = h;
        e.t = e_t; e.s = e_s; e.d = e_d; e.l = e_l; e.go = e_go; e.hp = hp; e.mp = mp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("targets",    16'(targets),    16'(e.t));
        chk("score",      score,           e.s);
        chk("difficulty", 16'(difficulty), 16'(e.d));
        chk("lives",      16'(lives),      16'(e.l));
        chk("game_over",  16'(game_over),  16'(e.go));
        chk("hit_pulse",  16'(hit_pulse),  16'(e.hp));
        chk("miss_pulse", 16'(miss_pulse), 16'(e.mp));
        tick = 1'b0;
    endtask

    task automatic spawn();
        int i;
        i = int'(lfsr_m) % 8;
        if (i == prev_m) i = (i + 1) % 8;
        prev_m = i;
        e_t = 8'd1 << i;
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("onehot", 16'($countones(targets)), 16'd1);
        if (last_t != 8'h00)
            chk("no_repeat", 16'(targets != last_t), 16'd1);
        last_t = e_t;
    endtask

    task automatic score_hit(input logic t);
        logic [7:0] h;
        h = e_t;
        e_t = '0;
        if (e_s != 16'hFFFF) e_s = e_s + 16'd1;
        e_d = (e_s / 5 > 4) ? 3'd4 : 3'(e_s / 5);
        cyc(t, h, 1'b1, 1'b0);
    endtask

    task automatic miss();
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        e_t = '0;
        if (e_l != 0) e_l = e_l - 3'd1;
        if (e_l == 0) e_go = 1'b1;
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        e_t = '0; e_s = '0; e_d = '0; e_l = 3'd3; e_go = 1'b0;
        prev_m = 0;
        last_t = '0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lfsr_seed", 16'(dut.lfsr), 16'h00A5);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] h;
        #2;
        do_reset();

        // start and first hit; a held button must not score again
        enable = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        spawn();
        h = e_t;
        score_hit(1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b0, h, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // timeout costs a life
        spawn();
        miss();

        // hit on the expiring tick wins over the miss
        spawn();
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        score_hit(1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // unlit press is harmless, then run out of lives
        spawn();
        h = {e_t[6:0], e_t[7]};
        cyc(1'b0, h, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        miss();
        spawn();
        miss();

        // game over: ticks and presses do nothing
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // disable holds score/lives, re-enable restarts
        enable = 1'b0;
        e_go = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        enable = 1'b1;
        e_s = '0; e_d = '0; e_l = 3'd3;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // 100 spawn/hit rounds: level-up, difficulty cap, no repeated target
        for (int n = 0; n < 100; n++) begin
            spawn();
            score_hit(1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            if (n == 4)  chk("diff_after_5",  16'(difficulty), 16'd1);
            if (n == 29) chk("score_after_30", score, 16'd30);
        end
        chk("diff_capped", 16'(difficulty), 16'd4);

        // asynchronous reset in the middle of SHOW
        spawn();
        do_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mole_ctrl.md
Name: mole_ctrl

Overview:
- Game-round controller that consumes the difficulty-scaled tick from the frequency generator.
- On each tick it lights one pseudo-randomly chosen target, watches the player hit buttons, scores hits, and charges lives on timeouts.
- Its difficulty output feeds the frequency generator's difficulty input, closing the loop.
- Sits between the tick generator and the LED/score display logic.

Parameters:
- NUM_TARGETS, 8, number of targets/buttons (2..16).
- SHOW_TICKS, 3, ticks a target stays lit before it counts as a miss (≥1).
- LEVEL_UP_HITS, 5, hits per difficulty increment.
- MAX_DIFF, 4, highest difficulty value issued.
- START_LIVES, 3, lives at game start (1..7).
- LFSR_SEED, 8'hA5, LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  game run; low forces IDLE.
- tick  in  1  tick from the frequency generator; each high cycle is one tick.
- hit  in  NUM_TARGETS  debounced button levels, bit i = target i.
- targets  out  NUM_TARGETS  one-hot lit target, 0 when none.
- score  out  16  hit count, saturating.
- difficulty  out  3  current level, to the frequency generator.
- lives  out  3  remaining lives.
- game_over  out  1  high in GAMEOVER.
- hit_pulse  out  1  one-cycle strobe on a scored hit.
- miss_pulse  out  1  one-cycle strobe on a timeout.

Behaviour:
- Reset (async, rst high): state=IDLE, targets=0, score=0, difficulty=0, lives=START_LIVES, game_over=0, strobes=0, lfsr=LFSR_SEED, hit_q=0, tick_cnt=0, hits_in_level=0, prev_idx=0.
- All outputs are registered; every state change takes effect on the next clk edge.
- Edge detect: hit_q<=hit every cycle. press = hit & ~hit_q. Held buttons never re-trigger.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle while enable=1 and holds when enable=0. idx = lfsr % NUM_TARGETS. If idx==prev_idx, use (idx+1) % NUM_TARGETS.
- IDLE:
  - targets=0, game_over=0.
  - When enable=1: clear score, difficulty, hits_in_level and tick_cnt; set lives=START_LIVES; go to WAIT.
- WAIT:
  - targets=0.
  - On tick=1: targets<=1<<idx, prev_idx<=idx, tick_cnt<=0, go to SHOW.
  - Presses are ignored.
- SHOW (evaluated in priority order each cycle):
  1. Hit: press has the lit bit set, even if other bits are also pressed. Then:
     - score+1, saturating at 16'hFFFF.
     - hit_pulse=1, targets<=0, hits_in_level+1.
     - If hits_in_level reaches LEVEL_UP_HITS: clear it, and if difficulty<MAX_DIFF, increment difficulty.
     - Go to WAIT.
     - A hit wins over a tick arriving in the same cycle.
  2. Miss: tick=1 and tick_cnt==SHOW_TICKS-1. Then:
     - miss_pulse=1, targets<=0, lives-1.
     - If lives becomes 0, go to GAMEOVER; otherwise go to WAIT.
  3. Tick=1 otherwise: tick_cnt+1.
  4. Presses on unlit bits only: ignored, no penalty.
- GAMEOVER:
  - targets=0, game_over=1.
  - score, difficulty and lives are held.
  - Ticks and presses are ignored.
- enable=0 in any state: next cycle state=IDLE, targets=0, game_over=0, strobes=0. score, difficulty and lives hold their last values until the next start.
- Latency:
  - tick→target lit: 1 cycle.
  - press→hit_pulse/score update: 1 cycle after the press edge is registered.
- Width rules:
  - difficulty never exceeds MAX_DIFF.
  - lives never underflows; the decrement occurs only when lives≥1.

Test Plan:
- Reset values: assert rst mid-SHOW with target 3 lit → next clk targets=0, score=0, difficulty=0, lives=3, lfsr=8'hA5, and the bench sees state IDLE.
- Hit path: enable=1, single tick → exactly one target bit set. Press that bit one cycle later → hit_pulse for 1 cycle, score=1, targets=0. Hold the button for 10 cycles → no further score.
- Miss path: light target, send 3 ticks with no press → miss_pulse on the 3rd tick, lives 3→2, targets=0. Repeat twice more → lives=0, game_over=1, subsequent ticks produce no target.
- Level-up: 5 consecutive hits → difficulty 0→1. After 25 hits → difficulty=4; 5 more hits → difficulty stays 4, score=30.
- Simultaneous: press on the lit bit in the same cycle as the expiring 3rd tick → hit_pulse=1, miss_pulse=0, lives unchanged. Press an unlit bit only → no score change, no life loss.
- Restart and no-repeat: deassert enable during GAMEOVER → IDLE with score held. Reassert → score=0, lives=3. Over 100 spawns, no two consecutive spawns light the same target.
